// File: rtl/mem_access_unit.sv
// Memory stage: issues aligned req/ack data-memory accesses for loads and stores,
// extends load data, and stalls the core until the access retires or times out.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  fn3,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        access_fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              tmo_q, tmo_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        fn3_q, fn3_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       load_data_q, load_data_d;

  logic              acc, illegal, misalign, bad;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new;

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  extend_load = {{24{b[7]}}, b};
      3'b001:  extend_load = {{16{h[15]}}, h};
      3'b100:  extend_load = {24'b0, b};
      3'b101:  extend_load = {16'b0, h};
      default: extend_load = rdata;
    endcase
  endfunction

  // Decode of the instruction currently presented by the execution stage.
  always_comb begin
    acc     = mem_read | mem_write;
    illegal = mem_write ? (fn3 > 3'b010) : ((fn3 == 3'b011) || (fn3[2:1] == 2'b11));
    case (fn3[1:0])
      2'b01:   misalign = alu_out[0];
      2'b10:   misalign = |alu_out[1:0];
      default: misalign = 1'b0;
    endcase
    bad = illegal | misalign;

    case (fn3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << alu_out[1:0];
        wdata_new = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        be_new    = alu_out[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{rs2_data[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = rs2_data;
      end
    endcase
    if (!mem_write) be_new = 4'b1111;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    fn3_d       = fn3_q;
    lane_d      = lane_q;
    load_data_d = load_data_q;
    cnt_inc     = cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (acc && !bad) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = {alu_out[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          fn3_d   = fn3;
          lane_d  = alu_out[1:0];
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        // An ack arriving on the final permitted cycle still completes normally.
        if (dmem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (!we_q) load_data_d = extend_load(fn3_q, lane_q, dmem_rdata);
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d     = S_DONE;
          req_d       = 1'b0;
          tmo_d       = 1'b1;
          load_data_d = '0;
          cnt_d       = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tmo_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      fn3_q       <= '0;
      lane_q      <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      fn3_q       <= fn3_d;
      lane_q      <= lane_d;
      load_data_q <= load_data_d;
    end
  end

  assign stall        = acc & ~bad & (state_q != S_DONE);
  assign access_fault = (acc & bad & (state_q == S_IDLE)) | ((state_q == S_DONE) & tmo_q);
  assign load_data    = load_data_q;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, multi-cycle corner
// sequences, and randomized accesses against an arithmetic reference model.
module tb_mem_access_unit;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  fn3;
  logic [31:0] alu_out, rs2_data;
  logic        stall;
  logic [31:0] load_data;
  logic        access_fault;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .fn3(fn3),
    .alu_out(alu_out), .rs2_data(rs2_data), .stall(stall), .load_data(load_data),
    .access_fault(access_fault), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int          stalls;
    int          reqs;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        fault;
    logic [31:0] ld;
    logic        unstable;
    logic        hung;
  } res_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    int          ack_at;
    logic [31:0] rdat;
    logic [31:0] e_ld;
    int          e_stalls;
    logic        e_fault;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Present one instruction and act as the bus slave, acking on REQ cycle ack_at (0 = never).
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d, input int ack_at,
                            input logic [31:0] rdat, output res_t r);
    logic done;
    r = '{default: 0};
    done = 1'b0;
    @(posedge clk);
    #1;
    mem_read = rd; mem_write = wr; fn3 = f3; alu_out = a; rs2_data = d; dmem_ack = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      if (stall) r.stalls++;
      if (dmem_req) begin
        r.reqs++;
        if (r.reqs == 1) begin
          r.be = dmem_be; r.addr = dmem_addr; r.wdata = dmem_wdata; r.we = dmem_we;
        end else if (dmem_be !== r.be || dmem_addr !== r.addr ||
                     dmem_wdata !== r.wdata || dmem_we !== r.we) begin
          r.unstable = 1'b1;
        end
        if (r.reqs == ack_at) begin
          dmem_ack = 1'b1; dmem_rdata = rdat;
        end else begin
          dmem_ack = 1'b0; dmem_rdata = $urandom;
        end
      end else begin
        dmem_ack = 1'b0;
      end
      if (!stall) begin
        r.fault = access_fault;
        r.ld    = load_data;
        done    = 1'b1;
      end
    end
    if (!done) r.hung = 1'b1;
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b0;
  endtask

  // Reference model: derives the expected bus transaction and result from access size arithmetic.
  function automatic res_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d, input int ack_at,
                                 input logic [31:0] rdat, input logic [31:0] ld_prev);
    res_t   e;
    int     nb, off;
    logic   badacc, ok;
    longint v;
    e = '{default: 0};
    nb  = 1 << f3[1:0];
    off = int'(a[1:0]);
    badacc = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    if (!badacc && (off % nb) != 0) badacc = 1'b1;
    e.ld = ld_prev;
    if (badacc) begin
      e.fault = 1'b1;
      return e;
    end
    ok       = (ack_at >= 1) && (ack_at <= T);
    e.reqs   = ok ? ack_at : T;
    e.stalls = e.reqs + 1;
    e.fault  = !ok;
    e.we     = wr;
    e.addr   = a & ~32'd3;
    e.be     = wr ? 4'(((1 << nb) - 1) << off) : 4'hF;
    e.wdata  = (nb == 1) ? (d & 32'hFF) * 32'h0101_0101 :
               (nb == 2) ? (d & 32'hFFFF) * 32'h0001_0001 : d;
    if (!ok) begin
      e.ld = 32'd0;
    end else if (!wr) begin
      v = longint'(rdat >> (8 * off)) & ((64'd1 << (8 * nb)) - 64'd1);
      if (!f3[2] && nb < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
      e.ld = v[31:0];
    end
    return e;
  endfunction

  task automatic compare(input string tag, input res_t g, input res_t e);
    chk({tag, ".stalls"}, 32'(g.stalls), 32'(e.stalls));
    chk({tag, ".reqs"},   32'(g.reqs),   32'(e.reqs));
    chk({tag, ".fault"},  32'(g.fault),  32'(e.fault));
    chk({tag, ".ld"},     g.ld,          e.ld);
    chk({tag, ".hung"},   32'(g.hung),   32'd0);
    if (e.reqs > 0) begin
      chk({tag, ".be"},     32'(g.be),       32'(e.be));
      chk({tag, ".addr"},   g.addr,          e.addr);
      chk({tag, ".we"},     32'(g.we),       32'(e.we));
      chk({tag, ".stable"}, 32'(g.unstable), 32'd0);
      if (e.we) chk({tag, ".wdata"}, g.wdata, e.wdata);
    end
  endtask

  vec_t        vt[15];
  res_t        r, e, r2;
  logic [31:0] ld_model;
  logic [31:0] ld_before;

  initial begin
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; fn3 = 3'd0; alu_out = '0; rs2_data = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;

    //            rd wr f3    addr         data          ack rdata         exp_ld        st  flt be     addr         wdata
    vt[0]  = '{1'b0, 1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 3,  32'h0,        32'h0,        4,  1'b0, 4'hF, 32'h104, 32'hDEADBEEF};
    vt[1]  = '{1'b1, 1'b0, 3'd0, 32'h203, 32'h0,        1,  32'h80123456, 32'hFFFFFF80, 2,  1'b0, 4'hF, 32'h200, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 3'd4, 32'h203, 32'h0,        2,  32'h80123456, 32'h00000080, 3,  1'b0, 4'hF, 32'h200, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 3'd1, 32'h002, 32'h1234ABCD, 1,  32'h0,        32'h00000080, 2,  1'b0, 4'hC, 32'h000, 32'hABCDABCD};
    vt[4]  = '{1'b1, 1'b0, 3'd1, 32'h001, 32'h0,        1,  32'h0,        32'h00000080, 0,  1'b1, 4'h0, 32'h0,   32'h0};
    vt[5]  = '{1'b1, 1'b0, 3'd2, 32'h010, 32'h0,        0,  32'h0,        32'h0,        17, 1'b1, 4'hF, 32'h010, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 3'd1, 32'h006, 32'h0,        2,  32'hFFFE1234, 32'hFFFFFFFE, 3,  1'b0, 4'hF, 32'h004, 32'h0};
    vt[7]  = '{1'b1, 1'b0, 3'd5, 32'h006, 32'h0,        1,  32'hFFFE1234, 32'h0000FFFE, 2,  1'b0, 4'hF, 32'h004, 32'h0};
    vt[8]  = '{1'b0, 1'b1, 3'd0, 32'h301, 32'hAABBCC77, 2,  32'h0,        32'h0000FFFE, 3,  1'b0, 4'h2, 32'h300, 32'h77777777};
    vt[9]  = '{1'b1, 1'b0, 3'd2, 32'h040, 32'h0,        16, 32'hCAFEF00D, 32'hCAFEF00D, 17, 1'b0, 4'hF, 32'h040, 32'h0};
    vt[10] = '{1'b0, 1'b1, 3'd3, 32'h000, 32'h0,        1,  32'h0,        32'hCAFEF00D, 0,  1'b1, 4'h0, 32'h0,   32'h0};
    vt[11] = '{1'b1, 1'b0, 3'd6, 32'h000, 32'h0,        1,  32'h0,        32'hCAFEF00D, 0,  1'b1, 4'h0, 32'h0,   32'h0};
    vt[12] = '{1'b0, 1'b1, 3'd2, 32'h102, 32'h0,        1,  32'h0,        32'hCAFEF00D, 0,  1'b1, 4'h0, 32'h0,   32'h0};
    vt[13] = '{1'b1, 1'b0, 3'd5, 32'h003, 32'h0,        1,  32'h0,        32'hCAFEF00D, 0,  1'b1, 4'h0, 32'h0,   32'h0};
    vt[14] = '{1'b1, 1'b1, 3'd2, 32'h008, 32'h01020304, 1,  32'h0,        32'hCAFEF00D, 2,  1'b0, 4'hF, 32'h008, 32'h01020304};

    repeat (3) @(negedge clk);
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.we", 32'(dmem_we), 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.be", 32'(dmem_be), 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.ld", load_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle.stall", 32'(stall), 32'd0);
    chk("idle.fault", 32'(access_fault), 32'd0);

    for (int i = 0; i < 15; i++) begin
      run_access(vt[i].rd, vt[i].wr, vt[i].f3, vt[i].a, vt[i].d, vt[i].ack_at, vt[i].rdat, r);
      chk($sformatf("vec%0d.stalls", i), 32'(r.stalls), 32'(vt[i].e_stalls));
      chk($sformatf("vec%0d.fault", i),  32'(r.fault),  32'(vt[i].e_fault));
      chk($sformatf("vec%0d.ld", i),     r.ld,          vt[i].e_ld);
      chk($sformatf("vec%0d.hung", i),   32'(r.hung),   32'd0);
      if (vt[i].e_stalls > 0) begin
        chk($sformatf("vec%0d.reqs", i), 32'(r.reqs), 32'(vt[i].e_stalls - 1));
        chk($sformatf("vec%0d.be", i),   32'(r.be),   32'(vt[i].e_be));
        chk($sformatf("vec%0d.addr", i), r.addr,      vt[i].e_addr);
        chk($sformatf("vec%0d.we", i),   32'(r.we),   32'(vt[i].wr));
        if (vt[i].wr) chk($sformatf("vec%0d.wdata", i), r.wdata, vt[i].e_wdata);
      end else begin
        chk($sformatf("vec%0d.noreq", i), 32'(r.reqs), 32'd0);
      end
    end
    go_idle();
    @(negedge clk);
    chk("bad.req_after", 32'(dmem_req), 32'd0);

    // Reset asserted while a load is outstanding on the bus.
    @(posedge clk);
    #1;
    mem_read = 1'b1; mem_write = 1'b0; fn3 = 3'd2; alu_out = 32'h60; dmem_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst.req_before", 32'(dmem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst.req", 32'(dmem_req), 32'd0);
    chk("midrst.ld", load_data, 32'd0);
    chk("midrst.addr", dmem_addr, 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst.noretry", 32'(dmem_req), 32'd0);
    chk("midrst.stall", 32'(stall), 32'd0);

    // Back-to-back LW then SW with immediate acks.
    run_access(1'b1, 1'b0, 3'd2, 32'h50, 32'h0, 1, 32'h11223344, r);
    run_access(1'b0, 1'b1, 3'd2, 32'h54, 32'h55667788, 1, 32'h0, r2);
    chk("b2b.lw.stalls", 32'(r.stalls), 32'd2);
    chk("b2b.lw.reqs", 32'(r.reqs), 32'd1);
    chk("b2b.lw.ld", r.ld, 32'h11223344);
    chk("b2b.sw.stalls", 32'(r2.stalls), 32'd2);
    chk("b2b.sw.reqs", 32'(r2.reqs), 32'd1);
    chk("b2b.sw.addr", r2.addr, 32'h54);
    chk("b2b.sw.wdata", r2.wdata, 32'h55667788);
    chk("b2b.sw.fault", 32'(r2.fault), 32'd0);
    go_idle();

    // Stray ack with no access in flight must be ignored.
    ld_before = load_data;
    dmem_ack = 1'b1; dmem_rdata = 32'hA5A5A5A5;
    repeat (3) @(negedge clk);
    chk("strayack.req", 32'(dmem_req), 32'd0);
    chk("strayack.ld", load_data, ld_before);
    dmem_ack = 1'b0;

    ld_model = load_data;
    for (int i = 0; i < 40; i++) begin
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] a, d, rd_word;
      int          op, ack_at, pick;
      op = $urandom_range(0, 2);
      rd = (op != 1);
      wr = (op != 0);
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      d  = $urandom;
      rd_word = $urandom;
      pick = $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) ack_at = (pick == 0) ? 0 : (pick == 1) ? T : T + 1;
      else ack_at = $urandom_range(1, 4);
      e = model(rd, wr, f3, a, d, ack_at, rd_word, ld_model);
      run_access(rd, wr, f3, a, d, ack_at, rd_word, r);
      compare($sformatf("rnd%0d", i), r, e);
      ld_model = e.ld;
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
